// File: rtl/fp_execute_stage3_if.sv
// Stage-2 to stage-3 bundle and stage-3 results for the FP execute pipe.
// Stand-in widths: decoded instruction 32b, lane mask one bit per lane,
// thread index 2b, subcycle 4b.
interface fp_execute_stage3_if #(
  parameter int NUM_VECTOR_LANES = 16
);
  // Inputs from stage 2
  logic                        fx2_instruction_valid;
  logic [31:0]                 fx2_instruction;
  logic [NUM_VECTOR_LANES-1:0] fx2_mask_value;
  logic [1:0]                  fx2_thread_idx;
  logic [3:0]                  fx2_subcycle;
  logic                        fx2_result_is_inf      [NUM_VECTOR_LANES];
  logic                        fx2_result_is_nan      [NUM_VECTOR_LANES];
  logic [5:0]                  fx2_ftoi_lshift        [NUM_VECTOR_LANES];
  logic [31:0]                 fx2_significand_le     [NUM_VECTOR_LANES];
  logic [31:0]                 fx2_significand_se     [NUM_VECTOR_LANES];
  logic                        fx2_logical_subtract   [NUM_VECTOR_LANES];
  logic                        fx2_guard              [NUM_VECTOR_LANES];
  logic                        fx2_round              [NUM_VECTOR_LANES];
  logic                        fx2_sticky             [NUM_VECTOR_LANES];
  logic [7:0]                  fx2_add_exponent       [NUM_VECTOR_LANES];
  logic                        fx2_add_result_sign    [NUM_VECTOR_LANES];
  logic [63:0]                 fx2_significand_product[NUM_VECTOR_LANES];
  logic [7:0]                  fx2_mul_exponent       [NUM_VECTOR_LANES];
  logic                        fx2_mul_sign           [NUM_VECTOR_LANES];

  // Outputs to stage 4
  logic                        fx3_instruction_valid;
  logic [31:0]                 fx3_instruction;
  logic [NUM_VECTOR_LANES-1:0] fx3_mask_value;
  logic [1:0]                  fx3_thread_idx;
  logic [3:0]                  fx3_subcycle;
  logic                        fx3_result_is_inf      [NUM_VECTOR_LANES];
  logic                        fx3_result_is_nan      [NUM_VECTOR_LANES];
  logic [5:0]                  fx3_ftoi_lshift        [NUM_VECTOR_LANES];
  logic                        fx3_logical_subtract   [NUM_VECTOR_LANES];
  logic [32:0]                 fx3_add_significand    [NUM_VECTOR_LANES];
  logic [5:0]                  fx3_leading_zeroes     [NUM_VECTOR_LANES];
  logic [7:0]                  fx3_add_exponent       [NUM_VECTOR_LANES];
  logic                        fx3_add_result_sign    [NUM_VECTOR_LANES];
  logic [63:0]                 fx3_significand_product[NUM_VECTOR_LANES];
  logic [7:0]                  fx3_mul_exponent       [NUM_VECTOR_LANES];
  logic                        fx3_mul_sign           [NUM_VECTOR_LANES];

  modport master (
    output fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx,
           fx2_subcycle, fx2_result_is_inf, fx2_result_is_nan, fx2_ftoi_lshift,
           fx2_significand_le, fx2_significand_se, fx2_logical_subtract, fx2_guard,
           fx2_round, fx2_sticky, fx2_add_exponent, fx2_add_result_sign,
           fx2_significand_product, fx2_mul_exponent, fx2_mul_sign,
    input  fx3_instruction_valid, fx3_instruction, fx3_mask_value, fx3_thread_idx,
           fx3_subcycle, fx3_result_is_inf, fx3_result_is_nan, fx3_ftoi_lshift,
           fx3_logical_subtract, fx3_add_significand, fx3_leading_zeroes,
           fx3_add_exponent, fx3_add_result_sign, fx3_significand_product,
           fx3_mul_exponent, fx3_mul_sign
  );

  modport slave (
    input  fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx,
           fx2_subcycle, fx2_result_is_inf, fx2_result_is_nan, fx2_ftoi_lshift,
           fx2_significand_le, fx2_significand_se, fx2_logical_subtract, fx2_guard,
           fx2_round, fx2_sticky, fx2_add_exponent, fx2_add_result_sign,
           fx2_significand_product, fx2_mul_exponent, fx2_mul_sign,
    output fx3_instruction_valid, fx3_instruction, fx3_mask_value, fx3_thread_idx,
           fx3_subcycle, fx3_result_is_inf, fx3_result_is_nan, fx3_ftoi_lshift,
           fx3_logical_subtract, fx3_add_significand, fx3_leading_zeroes,
           fx3_add_exponent, fx3_add_result_sign, fx3_significand_product,
           fx3_mul_exponent, fx3_mul_sign
  );
endinterface

// File: rtl/fp_execute_stage3.sv
// FP execute stage 3: per-lane significand add/subtract with g/r/s handling
// and a 33-bit leading-zero count for the stage-4 normalize shift. Everything
// else is registered straight through. One-cycle latency, no stall.
// Optional build macro FP_STAGE3_ADD_ROUND_EN: apply round-to-nearest-even on
// adds here; when undefined, adds are truncated and stage 4 rounds.
module fp_execute_stage3 #(
  parameter int NUM_VECTOR_LANES = 16
) (
  input logic            clk,
  input logic            reset,
  fp_execute_stage3_if.slave fx_if
);

  typedef struct packed {
    logic        result_is_inf;
    logic        result_is_nan;
    logic [5:0]  ftoi_lshift;
    logic [7:0]  add_exponent;
    logic        add_result_sign;
    logic [63:0] significand_product;
    logic [7:0]  mul_exponent;
    logic        mul_sign;
    logic        logical_subtract;
    logic [32:0] add_significand;
    logic [5:0]  leading_zeroes;
  } lane_t;

  logic                        valid_d, valid_q;
  logic [31:0]                 instruction_d, instruction_q;
  logic [NUM_VECTOR_LANES-1:0] mask_value_d, mask_value_q;
  logic [1:0]                  thread_idx_d, thread_idx_q;
  logic [3:0]                  subcycle_d, subcycle_q;
  lane_t                       lane_d [NUM_VECTOR_LANES];
  lane_t                       lane_q [NUM_VECTOR_LANES];

  // Borrow on subtract comes from any bit lost during alignment; carry-in on
  // add is only the optional rounding increment.
  function automatic logic [32:0] add_sub(input logic [31:0] le, input logic [31:0] se,
                                          input logic sub, input logic g,
                                          input logic r, input logic s);
    logic borrow;
    logic round_up;
    borrow = g | r | s;
`ifdef FP_STAGE3_ADD_ROUND_EN
    round_up = g & (r | s | (le[0] ^ se[0]));
`else
    round_up = 1'b0;
`endif
    if (sub) add_sub = {1'b0, le} - {1'b0, se} - {32'b0, borrow};
    else     add_sub = {1'b0, le} + {1'b0, se} + {32'b0, round_up};
  endfunction

  function automatic logic [5:0] clz33(input logic [32:0] v);
    logic found;
    clz33 = 6'd33;
    found = 1'b0;
    for (int i = 32; i >= 0; i--) begin
      if (!found && v[i]) begin
        clz33 = 6'(32 - i);
        found = 1'b1;
      end
    end
  endfunction

  // Next-state: sideband passthrough plus per-lane arithmetic on every lane.
  always_comb begin
    valid_d       = fx_if.fx2_instruction_valid;
    instruction_d = fx_if.fx2_instruction;
    mask_value_d  = fx_if.fx2_mask_value;
    thread_idx_d  = fx_if.fx2_thread_idx;
    subcycle_d    = fx_if.fx2_subcycle;
    for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
      lane_d[i]                     = '0;
      lane_d[i].result_is_inf       = fx_if.fx2_result_is_inf[i];
      lane_d[i].result_is_nan       = fx_if.fx2_result_is_nan[i];
      lane_d[i].ftoi_lshift         = fx_if.fx2_ftoi_lshift[i];
      lane_d[i].add_exponent        = fx_if.fx2_add_exponent[i];
      lane_d[i].add_result_sign     = fx_if.fx2_add_result_sign[i];
      lane_d[i].significand_product = fx_if.fx2_significand_product[i];
      lane_d[i].mul_exponent        = fx_if.fx2_mul_exponent[i];
      lane_d[i].mul_sign            = fx_if.fx2_mul_sign[i];
      lane_d[i].logical_subtract    = fx_if.fx2_logical_subtract[i];
      lane_d[i].add_significand     = add_sub(fx_if.fx2_significand_le[i],
                                              fx_if.fx2_significand_se[i],
                                              fx_if.fx2_logical_subtract[i],
                                              fx_if.fx2_guard[i],
                                              fx_if.fx2_round[i],
                                              fx_if.fx2_sticky[i]);
      lane_d[i].leading_zeroes      = clz33(lane_d[i].add_significand);
    end
  end

  // Pipeline register; reset clears everything and drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      instruction_q <= '0;
      mask_value_q  <= '0;
      thread_idx_q  <= '0;
      subcycle_q    <= '0;
      for (int i = 0; i < NUM_VECTOR_LANES; i++) lane_q[i] <= '0;
    end else begin
      valid_q       <= valid_d;
      instruction_q <= instruction_d;
      mask_value_q  <= mask_value_d;
      thread_idx_q  <= thread_idx_d;
      subcycle_q    <= subcycle_d;
      for (int i = 0; i < NUM_VECTOR_LANES; i++) lane_q[i] <= lane_d[i];
    end
  end

  assign fx_if.fx3_instruction_valid = valid_q;
  assign fx_if.fx3_instruction       = instruction_q;
  assign fx_if.fx3_mask_value        = mask_value_q;
  assign fx_if.fx3_thread_idx        = thread_idx_q;
  assign fx_if.fx3_subcycle          = subcycle_q;

  // Fan registered lane fields out to the stage-4 bus.
  always_comb begin
    for (int i = 0; i < NUM_VECTOR_LANES; i++) begin
      fx_if.fx3_result_is_inf[i]       = lane_q[i].result_is_inf;
      fx_if.fx3_result_is_nan[i]       = lane_q[i].result_is_nan;
      fx_if.fx3_ftoi_lshift[i]         = lane_q[i].ftoi_lshift;
      fx_if.fx3_logical_subtract[i]    = lane_q[i].logical_subtract;
      fx_if.fx3_add_significand[i]     = lane_q[i].add_significand;
      fx_if.fx3_leading_zeroes[i]      = lane_q[i].leading_zeroes;
      fx_if.fx3_add_exponent[i]        = lane_q[i].add_exponent;
      fx_if.fx3_add_result_sign[i]     = lane_q[i].add_result_sign;
      fx_if.fx3_significand_product[i] = lane_q[i].significand_product;
      fx_if.fx3_mul_exponent[i]        = lane_q[i].mul_exponent;
      fx_if.fx3_mul_sign[i]            = lane_q[i].mul_sign;
    end
  end

endmodule

// File: tb/tb_fp_execute_stage3.sv
// Scoreboard bench for fp_execute_stage3: every driven cycle pushes a
// reference-model expectation that is popped and compared one cycle later.
module tb_fp_execute_stage3;
  localparam int L = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_execute_stage3_if #(.NUM_VECTOR_LANES(L)) fx_if();
  fp_execute_stage3 #(.NUM_VECTOR_LANES(L)) dut (.clk(clk), .reset(reset), .fx_if(fx_if));

  typedef struct packed {
    logic [31:0] le;
    logic [31:0] se;
    logic        sub;
    logic        g;
    logic        r;
    logic        s;
    logic        inf;
    logic        nan;
    logic [5:0]  ftoi;
    logic [7:0]  add_exp;
    logic        add_sign;
    logic [63:0] product;
    logic [7:0]  mul_exp;
    logic        mul_sign;
  } lane_in_t;

  typedef struct packed {
    logic [32:0] sig;
    logic [5:0]  lz;
    logic [63:0] product;
    logic [26:0] pass;
  } exp_lane_t;

  typedef struct packed {
    logic [54:0]           hdr;
    exp_lane_t [L-1:0]     lanes;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  lane_in_t       lin [L];
  logic           v_in;
  logic [31:0]    instr_in;
  logic [L-1:0]   mask_in;
  logic [1:0]     thr_in;
  logic [3:0]     sc_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_lane_t model(input lane_in_t x);
    exp_lane_t     m;
    longint unsigned a, b, res;
    logic          ru;
    logic [32:0]   t;
    int            p;
    a = longint'(x.le);
    b = longint'(x.se);
`ifdef FP_STAGE3_ADD_ROUND_EN
    ru = x.g & (x.r | x.s | (x.le[0] ^ x.se[0]));
`else
    ru = 1'b0;
`endif
    if (x.sub) res = a - b - longint'(x.g | x.r | x.s);
    else       res = a + b + longint'(ru);
    m.sig = res[32:0];
    if (m.sig == 33'd0) m.lz = 6'd33;
    else begin
      t = m.sig;
      p = 0;
      while (t > 33'd1) begin
        t = t >> 1;
        p++;
      end
      m.lz = 6'(32 - p);
    end
    m.product = x.product;
    m.pass = {x.inf, x.nan, x.ftoi, x.add_exp, x.add_sign, x.mul_exp, x.mul_sign, x.sub};
    return m;
  endfunction

  function automatic lane_in_t rand_lane();
    lane_in_t x;
    logic     borrow;
    x = '0;
    x.le = $urandom; x.se = $urandom;
    x.sub = 1'($urandom); x.g = 1'($urandom); x.r = 1'($urandom); x.s = 1'($urandom);
    x.inf = 1'($urandom); x.nan = 1'($urandom); x.ftoi = 6'($urandom);
    x.add_exp = 8'($urandom); x.add_sign = 1'($urandom);
    x.product = {$urandom, $urandom}; x.mul_exp = 8'($urandom); x.mul_sign = 1'($urandom);
    if (x.sub) begin
      borrow = x.g | x.r | x.s;
      if (x.le == 32'd0) x.le = 32'd1;
      x.se = $urandom_range(x.le - {31'd0, borrow}, 0);
    end
    return x;
  endfunction

  task automatic zero_lanes();
    for (int i = 0; i < L; i++) lin[i] = '0;
  endtask

  task automatic rand_all();
    for (int i = 0; i < L; i++) lin[i] = rand_lane();
  endtask

  // Drive one cycle, push the expectation, then check at edge+1.
  task automatic cycle();
    exp_t e, got;
    fx_if.fx2_instruction_valid = v_in;
    fx_if.fx2_instruction = instr_in;
    fx_if.fx2_mask_value = mask_in;
    fx_if.fx2_thread_idx = thr_in;
    fx_if.fx2_subcycle = sc_in;
    for (int i = 0; i < L; i++) begin
      fx_if.fx2_significand_le[i] = lin[i].le;
      fx_if.fx2_significand_se[i] = lin[i].se;
      fx_if.fx2_logical_subtract[i] = lin[i].sub;
      fx_if.fx2_guard[i] = lin[i].g;
      fx_if.fx2_round[i] = lin[i].r;
      fx_if.fx2_sticky[i] = lin[i].s;
      fx_if.fx2_result_is_inf[i] = lin[i].inf;
      fx_if.fx2_result_is_nan[i] = lin[i].nan;
      fx_if.fx2_ftoi_lshift[i] = lin[i].ftoi;
      fx_if.fx2_add_exponent[i] = lin[i].add_exp;
      fx_if.fx2_add_result_sign[i] = lin[i].add_sign;
      fx_if.fx2_significand_product[i] = lin[i].product;
      fx_if.fx2_mul_exponent[i] = lin[i].mul_exp;
      fx_if.fx2_mul_sign[i] = lin[i].mul_sign;
    end
    e = '0;
    if (!reset) begin
      e.hdr = {v_in, instr_in, mask_in, thr_in, sc_in};
      for (int i = 0; i < L; i++) e.lanes[i] = model(lin[i]);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      got.hdr = {fx_if.fx3_instruction_valid, fx_if.fx3_instruction, fx_if.fx3_mask_value,
                 fx_if.fx3_thread_idx, fx_if.fx3_subcycle};
      chk("hdr", 64'(got.hdr), 64'(e.hdr));
      for (int i = 0; i < L; i++) begin
        chk($sformatf("sig[%0d]", i), 64'(fx_if.fx3_add_significand[i]), 64'(e.lanes[i].sig));
        chk($sformatf("lz[%0d]", i), 64'(fx_if.fx3_leading_zeroes[i]), 64'(e.lanes[i].lz));
        chk($sformatf("prod[%0d]", i), fx_if.fx3_significand_product[i], e.lanes[i].product);
        chk($sformatf("pass[%0d]", i),
            64'({fx_if.fx3_result_is_inf[i], fx_if.fx3_result_is_nan[i], fx_if.fx3_ftoi_lshift[i],
                 fx_if.fx3_add_exponent[i], fx_if.fx3_add_result_sign[i], fx_if.fx3_mul_exponent[i],
                 fx_if.fx3_mul_sign[i], fx_if.fx3_logical_subtract[i]}),
            64'(e.lanes[i].pass));
      end
    end
  endtask

  initial begin
    reset = 1'b1; v_in = 1'b1; instr_in = 32'hdead_beef; mask_in = 16'hffff;
    thr_in = 2'd3; sc_in = 4'd5;
    rand_all();
    // Reset for two cycles with valid asserted
    cycle();
    cycle();
    chk("rst_valid", 64'(fx_if.fx3_instruction_valid), 64'd0);
    chk("rst_sig0", 64'(fx_if.fx3_add_significand[0]), 64'd0);
    reset = 1'b0;
    cycle();
    chk("valid_after_rst", 64'(fx_if.fx3_instruction_valid), 64'd1);

    // Plain add
    zero_lanes();
    lin[0].le = 32'h0080_0000; lin[0].se = 32'h0040_0000;
    cycle();
    chk("add_sig", 64'(fx_if.fx3_add_significand[0]), 64'h0_00C0_0000);
    chk("add_lz", 64'(fx_if.fx3_leading_zeroes[0]), 64'd9);

    // Subtract with sticky borrow
    zero_lanes();
    lin[0].le = 32'h0080_0000; lin[0].se = 32'h0000_0001; lin[0].sub = 1'b1; lin[0].s = 1'b1;
    cycle();
    chk("sub_sig", 64'(fx_if.fx3_add_significand[0]), 64'h0_007F_FFFE);
    chk("sub_lz", 64'(fx_if.fx3_leading_zeroes[0]), 64'd10);

    // Exact cancellation
    zero_lanes();
    lin[0].le = 32'h0080_0000; lin[0].se = 32'h0080_0000; lin[0].sub = 1'b1;
    cycle();
    chk("zero_sig", 64'(fx_if.fx3_add_significand[0]), 64'd0);
    chk("zero_lz", 64'(fx_if.fx3_leading_zeroes[0]), 64'd33);

    // Guard-only rounding on add
    zero_lanes();
    lin[0].le = 32'h0080_0001; lin[0].g = 1'b1;
    cycle();
`ifdef FP_STAGE3_ADD_ROUND_EN
    chk("rnd_sig", 64'(fx_if.fx3_add_significand[0]), 64'h0_0080_0002);
`else
    chk("rnd_sig", 64'(fx_if.fx3_add_significand[0]), 64'h0_0080_0001);
`endif

    // Carry-out
    zero_lanes();
    lin[0].le = 32'h8000_0000; lin[0].se = 32'h8000_0000;
    cycle();
    chk("cout_sig", 64'(fx_if.fx3_add_significand[0]), 64'h1_0000_0000);
    chk("cout_lz", 64'(fx_if.fx3_leading_zeroes[0]), 64'd0);

    // Back-to-back ops with distinct sideband
    for (int k = 0; k < 4; k++) begin
      rand_all();
      v_in = 1'b1; instr_in = 32'h1000 + 32'(k); mask_in = 16'h1 << k;
      thr_in = 2'(k); sc_in = 4'(k + 1);
      lin[0].product = 64'h0000_0001_0000_0000 + 64'(k);
      lin[0].mul_exp = 8'h81; lin[0].mul_sign = 1'b1;
      cycle();
    end

    // Lane 0 add and lane 15 subtract in the same cycle
    rand_all();
    lin[0].sub = 1'b0; lin[0].le = 32'h1234_5678; lin[0].se = 32'h0000_9abc;
    lin[15].sub = 1'b1; lin[15].le = 32'h4000_0000; lin[15].se = 32'h0fff_ffff;
    lin[15].g = 1'b1; lin[15].r = 1'b0; lin[15].s = 1'b0;
    cycle();
    chk("lane15_sig", 64'(fx_if.fx3_add_significand[15]), 64'h0_3000_0000);

    // Random traffic with random valid
    for (int k = 0; k < 30; k++) begin
      rand_all();
      v_in = 1'($urandom); instr_in = $urandom; mask_in = 16'($urandom);
      thr_in = 2'($urandom); sc_in = 4'($urandom);
      cycle();
    end

    // Mid-stream reset drops the in-flight op
    rand_all();
    reset = 1'b1; v_in = 1'b1;
    cycle();
    reset = 1'b0; v_in = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
